// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and default parameters for the clock divider
package clk_div_pkg;
    typedef enum logic [1:0] {OFF, RUN, SWITCH, STOP} state_t;
    localparam int RATIO_W_DEF   = 32;
    localparam int MIN_RATIO_DEF = 2;
endpackage

// File: rtl/clk_div_core.sv
// clk_div_core: period counter, registered divided clock and end-of-period decode
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int RATIO_W = RATIO_W_DEF
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               run,
    input  logic [RATIO_W-1:0] ratio,
    output logic               clk_out,
    output logic               period_tick,
    output logic               wrap
);
    logic [RATIO_W-1:0] count;
    logic last, half;
    assign last = count == ratio - RATIO_W'(1);
    assign half = count == (ratio >> 1) - RATIO_W'(1);
    assign wrap = run & last;
    assign period_tick = wrap;
    always_ff @(posedge clk_in) begin
        if (reset || !run) begin
            count   <= '0;
            clk_out <= 1'b0;
        end else begin
            count   <= last ? '0 : count + RATIO_W'(1);
            clk_out <= last ? 1'b0 : half ? 1'b1 : clk_out;
        end
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: ratio handshake, pending-ratio switch and graceful start/stop FSM
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int RATIO_W   = RATIO_W_DEF,
    parameter int MIN_RATIO = MIN_RATIO_DEF
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               en,
    input  logic               cfg_valid,
    input  logic [RATIO_W-1:0] cfg_ratio,
    output logic               cfg_ready,
    output logic               cfg_err,
    output logic               clk_out,
    output logic               period_tick,
    output logic [RATIO_W-1:0] ratio_active,
    output logic               busy
);
    state_t state, state_nx;
    logic [RATIO_W-1:0] pending;
    logic accept, legal, wrap, load_pending;
    assign cfg_ready = state == OFF || state == RUN;
    assign accept = cfg_valid & cfg_ready;
    assign legal = cfg_ratio >= RATIO_W'(MIN_RATIO);
    assign busy = state != OFF;
    // pending is only ever nonzero after a legal ratio arrived in RUN
    assign load_pending = wrap && (state == SWITCH || state == STOP) && pending != '0;
    always_comb begin
        state_nx = state;
        case (state)
            OFF:     state_nx = (en && ratio_active >= RATIO_W'(MIN_RATIO)) ? RUN : OFF;
            RUN:     state_nx = !en ? STOP : (accept && legal) ? SWITCH : RUN;
            SWITCH:  state_nx = !en ? STOP : wrap ? RUN : SWITCH;
            default: state_nx = wrap ? OFF : STOP;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state        <= OFF;
            pending      <= '0;
            ratio_active <= '0;
            cfg_err      <= 1'b0;
        end else begin
            state   <= state_nx;
            cfg_err <= accept & ~legal;
            if (accept && legal && state == OFF)
                ratio_active <= cfg_ratio;
            if (accept && legal && state == RUN)
                pending <= cfg_ratio;
            if (load_pending) begin
                ratio_active <= pending;
                pending      <= '0;
            end
        end
    end
    clk_div_core #(.RATIO_W(RATIO_W)) u_core (
        .clk_in      (clk_in),
        .reset       (reset),
        .run         (busy),
        .ratio       (ratio_active),
        .clk_out     (clk_out),
        .period_tick (period_tick),
        .wrap        (wrap)
    );
endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter RATIO_W, default 32, width of all ratio fields.
REQ-002 Parameter MIN_RATIO, default 2, smallest legal divide ratio.
REQ-003 clk_in  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 en  input  1  run request; 1 = produce divided clock, 0 = stop gracefully.
REQ-006 cfg_valid  input  1  new ratio offered on cfg_ratio.
REQ-007 cfg_ratio  input  RATIO_W  requested divide ratio.
REQ-008 cfg_ready  output  1  controller can accept a ratio this cycle.
REQ-009 cfg_err  output  1  one-cycle pulse: accepted ratio was illegal (< MIN_RATIO) and was discarded.
REQ-010 clk_out  output  1  divided clock, registered.
REQ-011 period_tick  output  1  one-cycle pulse in the last cycle of each divider period.
REQ-012 ratio_active  output  RATIO_W  ratio currently driving the divider; 0 = none loaded.
REQ-013 busy  output  1  high when state is not OFF.

Function
REQ-014 Handshake: a ratio transfers when cfg_valid & cfg_ready are both high on a rising edge.
REQ-015 States: OFF, RUN, SWITCH, STOP.
REQ-016 In OFF: counter = 0, clk_out = 0, cfg_ready = 1, and a legal accepted ratio loads into ratio_active on the next cycle.
REQ-017 OFF -> RUN when en = 1 and ratio_active >= MIN_RATIO; the counter starts at 0 in the first RUN cycle.
REQ-018 Divider counter runs 0..R-1 with R = ratio_active, then wraps to 0.
REQ-019 clk_out goes to 1 on the cycle after count == R/2-1 (integer division).
REQ-020 clk_out goes to 0 on the cycle after count == R-1.
REQ-021 Waveform result: low phase = R/2 cycles, high phase = R-R/2 cycles.
REQ-022 period_tick = 1 exactly in cycles where count == R-1 and state is not OFF.
REQ-023 In RUN: cfg_ready = 1; a legal accepted ratio is stored in a pending register and the state goes to SWITCH.
REQ-024 In SWITCH: cfg_ready = 0; at the next wrap, pending is copied to ratio_active, so the new R governs from count 0; state then returns to RUN.
REQ-025 Illegal ratio accepted in any state: cfg_err pulses the following cycle, and no state, pending or ratio_active change occurs.
REQ-026 Acceptance in the same cycle as a wrap (RUN): the current wrap uses the old R, and the new R applies at the following wrap.
REQ-027 en = 0 in RUN or SWITCH -> STOP.
REQ-028 In STOP: cfg_ready = 0; the current period completes; at the wrap any pending ratio loads into ratio_active, then state -> OFF with clk_out = 0.
REQ-029 en returning to 1 during STOP does not cancel the stop; OFF then restarts per REQ-017.
REQ-030 The counter is RATIO_W wide and never exceeds R-1, so no overflow is possible.
REQ-031 The R/2 comparison uses a logical right shift.

Reset
REQ-032 On reset = 1 at a clock edge: state = OFF, counter = 0, clk_out = 0, period_tick = 0, cfg_err = 0, ratio_active = 0, pending = 0, cfg_ready = 1 (combinational from OFF), busy = 0.
REQ-033 Reset mid-period or mid-SWITCH discards the pending ratio, and clk_out is 0 in the first post-reset cycle.

Structure
REQ-034 Shared package clk_div_pkg holds the state enum (OFF, RUN, SWITCH, STOP), the RATIO_W default and the MIN_RATIO default.
REQ-035 Sub-module clk_div_core holds the counter, the clk_out register and the period_tick decode.
REQ-036 clk_div_core inputs: run, ratio. Output: wrap pulse.
REQ-037 clk_div_ctrl holds the FSM, the pending register and the handshake logic.

Verification
REQ-038 Reset, load ratio 4 in OFF, en = 1 -> clk_out pattern 0,0,1,1 repeating; period_tick every 4th cycle; ratio_active = 4.
REQ-039 Odd ratio 5 -> low 2 cycles, high 3 cycles; busy = 1; period_tick period 5.
REQ-040 Running at 4, send ratio 6 mid-period -> cfg_ready drops; old 4-cycle period completes; next period is 6 cycles (low 3, high 3); then RUN with cfg_ready = 1.
REQ-041 Send ratio 1 and ratio 0 while running at 4 -> cfg_err pulses once each; waveform and ratio_active stay unchanged.
REQ-042 Drop en at count 1 of ratio 8 -> period finishes (period_tick at count 7), then OFF, clk_out = 0, busy = 0.
REQ-043 Assert reset during SWITCH (pending 10, active 4) -> all outputs reset, ratio_active = 0; en = 1 alone does not start until a ratio is loaded.
